// File: rtl/cmd_frame_pkg.sv
// cmd_frame_pkg: shared state encoding, default header bytes and pointer sizing
package cmd_frame_pkg;
  typedef enum logic [2:0] {IDLE, HUNT, BODY, PEND, PEND2} state_t;
  localparam logic [7:0] DEF_HEAD = 8'hEB;
  localparam logic [7:0] DEF_FLAG = 8'h90;
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/frame_buf.sv
// frame_buf: frame buffer with write/commit/read pointers, last-byte flags and registered fwft output
module frame_buf
  import cmd_frame_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  input  logic          commit,
  input  logic          rewind,
  input  logic          rd_en,
  output logic          valid,
  output logic          last,
  output logic          full,
  output logic [DW-1:0] dout,
  output logic [AW:0]   usedw
);
  localparam int PW = ptr_w(AW);
  logic [DW-1:0] mem [2**AW];
  logic [2**AW-1:0] lastf;
  logic [PW-1:0] wr, cp, rd, wr_nx, rd_nx;
  logic [AW-1:0] lidx;
  assign valid = rd != cp;
  assign last = valid & lastf[rd[AW-1:0]];
  assign full = (wr ^ rd) == {1'b1, {AW{1'b0}}};
  assign usedw = wr - rd;
  assign wr_nx = wr + PW'(we);
  assign rd_nx = rd + PW'(valid & rd_en);
  assign lidx = wr_nx[AW-1:0] - AW'(1);
  always_ff @(posedge clk)
    if (we) mem[wr[AW-1:0]] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      cp <= '0;
      rd <= '0;
      lastf <= '0;
      dout <= '0;
    end else begin
      wr <= rewind ? cp : wr_nx;
      rd <= rd_nx;
      dout <= (we && wr[AW-1:0] == rd_nx[AW-1:0]) ? wdata : mem[rd_nx[AW-1:0]];
      if (we) lastf[wr[AW-1:0]] <= 1'b0;
      if (commit) begin
        cp <= wr_nx;
        lastf[lidx] <= 1'b1;
      end
    end
endmodule

// File: rtl/cmd_frame_splitter.sv
// cmd_frame_splitter: extracts header-delimited command frames from a byte stream and releases whole frames
module cmd_frame_splitter
  import cmd_frame_pkg::*;
#(
  parameter int            DW      = 8,
  parameter logic [DW-1:0] HEAD    = DW'(DEF_HEAD),
  parameter logic [DW-1:0] FLAG    = DW'(DEF_FLAG),
  parameter int            AW      = 8,
  parameter int            MAX_LEN = 256,
  parameter int            TIMEOUT = 12000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wen,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic          cmdend,
  output logic          drop,
  output logic [AW:0]   usedw
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_nx;
  logic [LW-1:0] len, len_nx;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] hold, hold_nx, wdata;
  logic we, wr_req, commit, rewind, full, tout, counting;
  assign counting = state inside {HUNT, BODY, PEND};
  assign tout = counting && !wen && tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      len <= '0;
      hold <= '0;
      tcnt <= '0;
      drop <= 1'b0;
    end else begin
      state <= state_nx;
      len <= len_nx;
      hold <= hold_nx;
      drop <= rewind;
      tcnt <= (wen || !counting || tout) ? '0 : tcnt + TW'(1);
    end
  always_comb begin
    state_nx = state;
    len_nx = len;
    hold_nx = hold;
    wr_req = 1'b0;
    wdata = HEAD;
    commit = 1'b0;
    case (state)
      IDLE: if (wen && din == HEAD) state_nx = HUNT;
      HUNT:
        if (wen) begin
          state_nx = din == FLAG ? BODY : din == HEAD ? HUNT : IDLE;
          len_nx = '0;
        end else if (tout) state_nx = IDLE;
      BODY:
        if (wen) begin
          state_nx = din == HEAD ? PEND : BODY;
          wr_req = din != HEAD;
          wdata = din;
        end else if (tout) begin
          commit = len != '0;
          state_nx = IDLE;
        end
      PEND:
        if (wen) begin
          state_nx = din == FLAG ? BODY : din == HEAD ? PEND : PEND2;
          commit = din == FLAG && len != '0;
          wr_req = din != FLAG;
          hold_nx = din;
          if (din == FLAG) len_nx = '0;
        end else if (tout) begin
          wr_req = 1'b1;
          commit = 1'b1;
          state_nx = IDLE;
        end
      PEND2: begin
        wr_req = 1'b1;
        wdata = hold;
        state_nx = BODY;
      end
      default: state_nx = IDLE;
    endcase
    rewind = wr_req && (full || len == LW'(MAX_LEN));
    we = wr_req && !rewind;
    if (we) len_nx = len + LW'(1);
    if (rewind) begin
      commit = 1'b0;
      state_nx = IDLE;
    end
  end
  frame_buf #(.DW(DW), .AW(AW)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .we(we),
    .wdata(wdata),
    .commit(commit),
    .rewind(rewind),
    .rd_en(ready),
    .valid(valid),
    .last(cmdend),
    .full(full),
    .dout(dout),
    .usedw(usedw)
  );
endmodule

// File: tb/tb_cmd_frame_splitter.sv
// tb_cmd_frame_splitter: directed frame scenarios checked against a byte-level frame model
module tb_cmd_frame_splitter;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int MAX_LEN = 8;
  localparam int TIMEOUT = 20;
  localparam int EB = 235;
  localparam int F9 = 144;
  localparam int GAP = -1;
  localparam int LAST = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wen = 1'b0;
  logic ready = 1'b1;
  logic [DW-1:0] din = '0;
  logic valid, cmdend, drop;
  logic [DW-1:0] dout;
  logic [AW:0] usedw;
  int passed = 0;
  int total = 0;
  int drops_seen = 0;
  int exp_drops = 0;
  int exp_q[$];
  int burst[$];

  cmd_frame_splitter #(
    .DW(DW), .HEAD(8'hEB), .FLAG(8'h90), .AW(AW), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .din(din), .ready(ready),
    .valid(valid), .dout(dout), .cmdend(cmdend), .drop(drop), .usedw(usedw)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
  endtask

  // frames are the stretches between non-overlapping header pairs within one burst
  task automatic flush();
    int hdr[$];
    for (int i = 0; i + 1 < burst.size(); i++)
      if (burst[i] == EB && burst[i+1] == F9) begin
        hdr.push_back(i);
        i++;
      end
    for (int h = 0; h < hdr.size(); h++) begin
      int s, e;
      s = hdr[h] + 2;
      e = (h + 1 < hdr.size()) ? hdr[h+1] : burst.size();
      if (e - s > MAX_LEN) exp_drops++;
      else for (int j = s; j < e; j++) exp_q.push_back((j == e - 1 ? LAST : 0) + burst[j]);
    end
    burst.delete();
  endtask

  task automatic model(input int toks[$]);
    foreach (toks[i])
      if (toks[i] == GAP) flush();
      else burst.push_back(toks[i]);
  endtask

  task automatic send(input int b);
    wen = 1'b1;
    din = b[DW-1:0];
    @(posedge clk);
    #1 wen = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int toks[$]);
    foreach (toks[i])
      if (toks[i] == GAP) begin
        repeat (TIMEOUT + 5) @(posedge clk);
        #1;
      end else send(toks[i]);
  endtask

  task automatic run(input int toks[$]);
    model(toks);
    drive(toks);
  endtask

  task automatic pin(input string name, input int want[$]);
    check({name, "_len"}, exp_q.size(), want.size());
    for (int i = 0; i < want.size() && i < exp_q.size(); i++) check(name, exp_q[i], want[i]);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_drops"}, drops_seen, exp_drops);
    check({name, "_valid_idle"}, int'(valid), 0);
  endtask

  always @(negedge clk)
    if (rst_n) begin
      if (drop) drops_seen++;
      if (valid && ready) begin
        if (exp_q.size() == 0) check("unexpected_out", (cmdend ? LAST : 0) + int'(dout), -1);
        else check("out", (cmdend ? LAST : 0) + int'(dout), exp_q.pop_front());
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t[$];
    int w[$];
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_valid", int'(valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_cmdend", int'(cmdend), 0);
    check("rst_drop", int'(drop), 0);
    check("rst_usedw", int'(usedw), 0);

    t = '{EB, F9, 1, 2, 3, GAP};
    model(t);
    w = '{1, 2, LAST + 3};
    pin("pin_s1", w);
    drive(t);
    drain("s1");

    t = '{EB, F9, 'h11, 'h22, EB, F9, 'h33, GAP};
    model(t);
    w = '{'h11, LAST + 'h22, LAST + 'h33};
    pin("pin_s2", w);
    drive(t);
    drain("s2");

    t = '{EB, F9, EB, 'h44, EB, EB, F9, 'h77, GAP};
    model(t);
    w = '{EB, 'h44, LAST + EB, LAST + 'h77};
    pin("pin_s3", w);
    drive(t);
    drain("s3");

    t = '{EB, F9, 1, 2, 3, 4, 5, 6, 7, 8, GAP};
    run(t);
    drain("maxlen");

    t = '{EB, F9, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    run(t);
    check("drop_pulse", drops_seen, 1);
    check("usedw_after_drop", int'(usedw), 0);
    t = '{EB, F9, 'h55, GAP};
    model(t);
    w = '{LAST + 'h55};
    pin("pin_s4", w);
    drive(t);
    drain("s4");

    ready = 1'b0;
    t = '{EB, F9, 1, 2, 3, GAP, EB, F9, 4, 5, 6, 7, GAP};
    model(t);
    w = '{1, 2, LAST + 3, 4, 5, 6, LAST + 7};
    pin("pin_s5", w);
    drive(t);
    check("held_usedw", int'(usedw), 7);
    check("held_valid", int'(valid), 1);
    check("held_dout", int'(dout), 1);
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("usedw_count", int'(usedw), 7 - k);
    end
    drain("s5");

    ready = 1'b0;
    t = '{EB, F9, 'h21, 'h22, GAP, EB, F9, 'h23};
    run(t);
    check("pre_rst_valid", int'(valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(valid), 0);
    check("arst_dout", int'(dout), 0);
    check("arst_cmdend", int'(cmdend), 0);
    check("arst_drop", int'(drop), 0);
    check("arst_usedw", int'(usedw), 0);
    exp_q.delete();
    burst.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    t = '{EB, F9, 'h66, GAP};
    model(t);
    w = '{LAST + 'h66};
    pin("pin_s6", w);
    drive(t);
    drain("s6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cmd_frame_splitter.md
# cmd_frame_splitter

Parametrised command-frame extractor for the SCI command path. It hunts a two-byte header (default EB 90) in a byte stream from the UART receiver. It buffers the payload that follows and ends the frame on the next header or on an inter-byte timeout. Only complete frames are released downstream, with a valid/ready handshake and an end-of-frame marker. Oversize frames and buffer overflow are dropped whole, never released partially.

## Interface
- DW, 8, data width
- HEAD, 8'hEB, first header byte
- FLAG, 8'h90, second header byte
- AW, 8, buffer address width; depth = 2^AW entries
- MAX_LEN, 256, maximum payload bytes per frame (1..2^AW)
- TIMEOUT, 12000, idle clk cycles that end a frame (1 ms at 12 MHz)
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- wen  in  1  input byte strobe; at most one strobe every 2 clk cycles
- din  in  DW  input byte, sampled when wen=1
- ready  in  1  downstream accepts dout this cycle
- valid  out  1  dout holds a byte of a committed frame
- dout  out  DW  payload byte
- cmdend  out  1  high with valid on the last byte of a frame
- drop  out  1  one-cycle pulse when an open frame is discarded
- usedw  out  AW+1  entries occupied, committed plus open

## Operation
- States: IDLE, HUNT, BODY, PEND, PEND2.
- IDLE: wen&HEAD -> HUNT.
- HUNT: wen&FLAG -> BODY and opens the frame (len=0). wen&HEAD -> HUNT. Other wen -> IDLE. Timeout -> IDLE.
- BODY: wen&HEAD -> PEND, with the byte held and not written. Other wen writes the byte, len+1. Timeout commits the frame if len>0, discards it silently if len=0, then -> IDLE.
- PEND: wen&FLAG commits the frame (empty frame discarded) and opens a new one -> BODY. wen&HEAD writes the held HEAD and stays in PEND. Other wen writes the held HEAD, latches din -> PEND2. Timeout writes the held HEAD, commits -> IDLE.
- PEND2: writes the latched byte -> BODY.
- Timeout counter: cleared on every wen. Counts only in HUNT/BODY/PEND. Fires when it reaches TIMEOUT-1.
- Overflow: a write when the buffer is full or len=MAX_LEN aborts the frame. The write pointer rewinds to the commit pointer, drop pulses, state -> IDLE. Later bytes are ignored until a new header.
- Buffer pointers: wr, commit, rd, each AW+1 bits with wrap bit.
- Commit copies wr to commit and sets the last-flag of entry wr-1. Every byte write clears the last-flag of its entry.
- Output: valid=1 while rd!=commit. A transfer occurs when valid&ready, and rd then advances by 1. cmdend = valid & last-flag[rd].
- Full: wr-rd == 2^AW. Committed data is never overwritten.

## Timing
- Reset: valid, dout, cmdend, drop = 0; usedw = 0; state IDLE; all pointers and counter 0. Reset mid-frame discards everything, including committed data.
- Write latency: 1 cycle from wen to buffer entry; PEND2 byte 1 cycle later.
- Commit on edge E -> valid high from cycle after E; dout is registered first-word-fall-through.
- Output throughput: 1 byte/cycle while ready=1.
- Simultaneous commit and read are legal. Read of the last committed byte concurrent with a new commit keeps valid high.
- Simultaneous timeout and wen: wen wins and the counter clears.

## Structure
- Package cmd_frame_pkg holds the state enum, default HEAD/FLAG constants, and the pointer-width helper.
- Sub-module frame_buf holds the dual-pointer RAM, last-flag array, commit/rewind ports, and full/usedw. The FSM, timeout counter and hold registers stay in the top level.

## Test plan
TIMEOUT=20 and MAX_LEN=8 on the bench for all scenarios.
- Feed EB 90 01 02 03, then idle for 20 cycles -> with ready=1 the output is 01 02 03, cmdend on 03, drop=0.
- Feed EB 90 11 22 EB 90 33, then timeout -> frames are {11 22} and {33}, with cmdend on 22 and on 33.
- Feed EB 90 EB 44 EB EB 90 -> payload EB 44 EB, the PEND/PEND2 path; the second EB 90 opens the next frame.
- Feed EB 90 plus 9 bytes -> drop pulses on the 9th byte and no bytes are output. usedw returns to the pre-frame value. A following EB 90 55 plus timeout yields 55.
- Hold ready=0 while frames of 3 and 4 bytes commit, then release -> 7 bytes in order, cmdend on the 3rd and 7th, usedw counts down to 0.
- Assert rst_n=0 mid-frame and while valid=1 -> all outputs 0 asynchronously; after release, EB 90 66 plus timeout yields 66 only.
